fir_out_quantizer: RTL and testbench
====================================

FIR_OUT_QUANTIZER -- requirements
Module: fir_out_quantizer

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 39: width of the signed FIR accumulator output consumed.
REQ-002 SHALL have parameter OUT_WIDTH, default 16: width of the signed quantized output.
REQ-003 SHALL have parameter SHIFT, default 15: arithmetic right-shift (coefficient fraction bits) applied before saturation.
REQ-004 SHALL have parameter DECIM, default 4: decimation ratio, 1..16.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4: output buffer entries, power of two.
REQ-006 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-008 SHALL have port in_valid, input, 1: din holds a new sample this cycle; tie to 1 when fed directly by fir_filter.
REQ-009 SHALL have port din, input, IN_WIDTH signed: FIR output sample.
REQ-010 SHALL have port dout, output, OUT_WIDTH signed: quantized, decimated sample at FIFO head.
REQ-011 SHALL have port dout_valid, output, 1: dout holds a valid sample.
REQ-012 SHALL have port dout_ready, input, 1: consumer accepts dout this cycle.
REQ-013 SHALL have port sat_pulse, output, 1: one-cycle pulse when a kept sample was clipped.
REQ-014 SHALL have port ovf_sticky, output, 1: a kept sample was dropped because the FIFO was full.
REQ-015 SHALL have port clr_ovf, input, 1: clears ovf_sticky.
REQ-016 SHALL have port fifo_level, output, clog2(FIFO_DEPTH)+1: current FIFO occupancy, 0..FIFO_DEPTH.

Function
REQ-017 Phase counter SHALL advance 0..DECIM-1, wrapping, once per cycle with in_valid=1; when in_valid=0 it SHALL hold.
REQ-018 A sample SHALL be kept only when in_valid=1 and phase=0; the first valid sample after reset is kept.
REQ-019 Stage 1 SHALL register (din + 2^(SHIFT-1)) >>> SHIFT, computed in IN_WIDTH+1 bits so no intermediate overflow (round half toward +inf).
REQ-020 Stage 2 SHALL clamp the stage-1 value to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] and assert sat_pulse for exactly the cycle the clipped value is offered for FIFO write.
REQ-021 A kept sample presented in cycle t SHALL be written to the FIFO at the edge ending cycle t+2; dout_valid SHALL be asserted in cycle t+3 if the FIFO was empty (latency 3).
REQ-022 FIFO SHALL be first-word-fall-through; pop occurs when dout_valid=1 and dout_ready=1; order preserved.
REQ-023 Write when full with no simultaneous pop: sample SHALL be discarded and ovf_sticky set; write when full with simultaneous pop: SHALL succeed, no drop.
REQ-024 clr_ovf SHALL clear ovf_sticky next edge; a drop in the same cycle SHALL win (flag stays 1).
REQ-025 fifo_level SHALL reflect push/pop of the previous edge; simultaneous push and pop leaves it unchanged.
REQ-026 dout SHALL remain stable while dout_valid=1 and dout_ready=0.

Reset
REQ-027 rst=1 SHALL, at the next edge, set dout=0, dout_valid=0, sat_pulse=0, ovf_sticky=0, fifo_level=0, phase=0, and clear both pipeline stages.
REQ-028 rst asserted mid-operation SHALL discard all in-flight and buffered samples; no sample presented during rst is kept.

Structure
REQ-029 Widths, default SHIFT/DECIM and saturation limits SHALL live in shared package fir_pkg with fir_filter.
REQ-030 Buffer SHALL be one sub-module, sync_fifo (parameterized width/depth, full/empty/level), instantiated once.

Verification (SHIFT=15, DECIM=4, FIFO_DEPTH=4)
REQ-031 din=32768000 held, in_valid=1, dout_ready=1 -> dout=1000 with dout_valid one cycle in every 4, first 3 cycles after first valid input.
REQ-032 DECIM=1, din=16384,16383,-16384,-16385 -> dout=1,0,0,-1.
REQ-033 din=2^38-1 then -2^38 -> dout=32767 then -32768, sat_pulse once per sample.
REQ-034 dout_ready=0, 5 kept samples 1..5 -> fifo_level=4, ovf_sticky=1; pulse clr_ovf -> 0; dout_ready=1 -> dout 1,2,3,4 in order.
REQ-035 FIFO full, pop and kept-sample write in same cycle -> fifo_level stays 4, ovf_sticky stays 0.
REQ-036 rst pulsed with fifo_level=3 -> next cycle dout_valid=0, fifo_level=0; first valid sample after rst emerges 3 cycles later.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants for the FIR datapath: default widths, shift, decimation and
// saturation limits used by fir_filter and fir_out_quantizer.
package fir_pkg;

    localparam int FIR_ACC_W      = 39;
    localparam int FIR_OUT_W      = 16;
    localparam int FIR_SHIFT      = 15;
    localparam int FIR_DECIM      = 4;
    localparam int FIR_FIFO_DEPTH = 4;

    typedef logic signed [FIR_OUT_W-1:0] fir_sample_t;

    // Two's-complement limits of a w-bit signed word (w up to 31).
    function automatic int fir_sat_max(input int w);
        return (32'sd1 <<< (w - 1)) - 32'sd1;
    endfunction

    function automatic int fir_sat_min(input int w);
        return -(32'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; a write while full is accepted
// only when a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push_s, pop_s;

    // Push/pop qualification and next pointer/level values.
    always_comb begin
        pop_s    = rd_en & (level_q != LW'(0));
        push_s   = wr_en & ((level_q != LW'(DEPTH)) | pop_s);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: the empty flag masks stale entries.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign empty   = (level_q == LW'(0));
    assign full    = (level_q == LW'(DEPTH));
    assign level   = level_q;
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/fir_out_quantizer.sv
// Decimates FIR accumulator output, rounds and saturates it to OUT_WIDTH bits,
// and buffers the result in a small FWFT FIFO with overflow reporting.
module fir_out_quantizer
    import fir_pkg::*;
#(
    parameter int IN_WIDTH   = FIR_ACC_W,
    parameter int OUT_WIDTH  = FIR_OUT_W,
    parameter int SHIFT      = FIR_SHIFT,
    parameter int DECIM      = FIR_DECIM,
    parameter int FIFO_DEPTH = FIR_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic signed [IN_WIDTH-1:0]    din,
    output logic signed [OUT_WIDTH-1:0]   dout,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic                          sat_pulse,
    output logic                          ovf_sticky,
    input  logic                          clr_ovf,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic signed [IN_WIDTH:0] RND =
        $signed({{(IN_WIDTH + 1 - SHIFT){1'b0}}, 1'b1, {(SHIFT - 1){1'b0}}});
    localparam logic signed [IN_WIDTH:0] SAT_HI = (IN_WIDTH + 1)'(fir_sat_max(OUT_WIDTH));
    localparam logic signed [IN_WIDTH:0] SAT_LO = (IN_WIDTH + 1)'(fir_sat_min(OUT_WIDTH));

    logic [PH_W-1:0]             phase_q, phase_d;
    logic                        keep_s;
    logic signed [IN_WIDTH:0]    sum_s;
    logic signed [IN_WIDTH:0]    s1_val_q, s1_val_d;
    logic                        s1_valid_q, s1_valid_d;
    logic signed [OUT_WIDTH-1:0] s2_val_q, s2_val_d;
    logic                        s2_valid_q, s2_valid_d;
    logic                        sat_q, sat_d;
    logic                        ovf_q, ovf_d;
    logic                        fifo_full_s, fifo_empty_s;
    logic                        pop_s, drop_s;
    logic [OUT_WIDTH-1:0]        fifo_rd_data_s;

    // Decimation phase and stage-1 round/shift in one extra bit of headroom.
    always_comb begin
        phase_d = phase_q;
        if (!in_valid) begin
            phase_d = phase_q;
        end else if (phase_q == PH_W'(DECIM - 1)) begin
            phase_d = '0;
        end else begin
            phase_d = phase_q + PH_W'(1);
        end
        keep_s     = in_valid & (phase_q == '0);
        sum_s      = $signed({din[IN_WIDTH-1], din}) + RND;
        s1_val_d   = sum_s >>> SHIFT;
        s1_valid_d = keep_s;
    end

    // Stage-2 clamp; the clip flag travels with the sample into the FIFO write slot.
    always_comb begin
        s2_val_d   = s1_val_q[OUT_WIDTH-1:0];
        sat_d      = 1'b0;
        s2_valid_d = s1_valid_q;
        if (s1_val_q > SAT_HI) begin
            s2_val_d = SAT_HI[OUT_WIDTH-1:0];
            sat_d    = s1_valid_q;
        end else if (s1_val_q < SAT_LO) begin
            s2_val_d = SAT_LO[OUT_WIDTH-1:0];
            sat_d    = s1_valid_q;
        end else begin
            s2_val_d = s1_val_q[OUT_WIDTH-1:0];
            sat_d    = 1'b0;
        end
    end

    // A drop is a write into a full FIFO that is not popped on the same edge; it beats clr_ovf.
    always_comb begin
        pop_s  = ~fifo_empty_s & dout_ready;
        drop_s = s2_valid_q & fifo_full_s & ~pop_s;
        ovf_d  = ovf_q;
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Pipeline, phase and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q    <= '0;
            s1_val_q   <= '0;
            s1_valid_q <= 1'b0;
            s2_val_q   <= '0;
            s2_valid_q <= 1'b0;
            sat_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            s1_val_q   <= s1_val_d;
            s1_valid_q <= s1_valid_d;
            s2_val_q   <= s2_val_d;
            s2_valid_q <= s2_valid_d;
            sat_q      <= sat_d;
            ovf_q      <= ovf_d;
        end
    end

    sync_fifo #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (s2_valid_q),
        .wr_data (s2_val_q),
        .rd_en   (dout_ready),
        .rd_data (fifo_rd_data_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .level   (fifo_level)
    );

    assign dout       = $signed(fifo_rd_data_s);
    assign dout_valid = ~fifo_empty_s;
    assign sat_pulse  = sat_q;
    assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_fir_out_quantizer.sv
// Directed bench for fir_out_quantizer: a default instance (DECIM=4) and a
// DECIM=1 instance sharing clock, reset and input samples.
module tb_fir_out_quantizer;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic signed [38:0] din;
    logic               dout_ready;
    logic               clr_ovf;

    logic signed [15:0] dout, dout1;
    logic               dout_valid, dout_valid1;
    logic               sat_pulse, sat1;
    logic               ovf_sticky, ovf1;
    logic [2:0]         fifo_level, level1;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    always #5 clk = ~clk;

    fir_out_quantizer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .din(din),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .sat_pulse(sat_pulse), .ovf_sticky(ovf_sticky), .clr_ovf(clr_ovf),
        .fifo_level(fifo_level)
    );

    fir_out_quantizer #(.DECIM(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .din(din),
        .dout(dout1), .dout_valid(dout_valid1), .dout_ready(1'b1),
        .sat_pulse(sat1), .ovf_sticky(ovf1), .clr_ovf(clr_ovf),
        .fifo_level(level1)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        chk_cnt++;
        if (got == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One reset edge; returns at the following negedge with rst released.
    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; din = '0; clr_ovf = 1'b0; dout_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    longint v32 [4] = '{16384, 16383, -16384, -16385};
    longint e32 [4] = '{1, 0, 0, -1};

    initial begin
        rst = 1'b1; in_valid = 1'b0; din = '0; clr_ovf = 1'b0; dout_ready = 1'b0;
        @(negedge clk);
        do_reset();
        chk("rst_valid", dout_valid, 0);
        chk("rst_dout", dout, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ovf", ovf_sticky, 0);
        chk("rst_sat", sat_pulse, 0);

        // Constant input, decimate by 4, latency 3
        dout_ready = 1'b1; in_valid = 1'b1; din = 39'sd32768000;
        for (int k = 0; k < 16; k++) begin
            chk("dec_valid", dout_valid, ((k >= 3) && ((k - 3) % 4 == 0)) ? 1 : 0);
            if ((k >= 3) && ((k - 3) % 4 == 0)) chk("dec_dout", dout, 1000);
            @(negedge clk);
        end

        // Rounding at DECIM=1
        do_reset();
        for (int k = 0; k < 8; k++) begin
            chk("rnd_valid", dout_valid1, (k >= 3 && k <= 6) ? 1 : 0);
            if (k >= 3 && k <= 6) chk("rnd_dout", dout1, e32[k-3]);
            in_valid = (k < 4);
            din      = (k < 4) ? 39'(v32[k]) : '0;
            @(negedge clk);
        end
        chk("rnd_level", level1, 0);

        // Saturation at DECIM=1
        do_reset();
        for (int k = 0; k < 7; k++) begin
            chk("sat_pulse", sat1, (k == 2 || k == 3) ? 1 : 0);
            chk("sat_valid", dout_valid1, (k == 3 || k == 4) ? 1 : 0);
            if (k == 3) chk("sat_hi", dout1, 32767);
            if (k == 4) chk("sat_lo", dout1, -32768);
            in_valid = (k < 2);
            din = (k == 0) ? 39'((longint'(1) << 38) - 1) :
                  (k == 1) ? 39'(-(longint'(1) << 38)) : '0;
            @(negedge clk);
        end
        chk("sat_ovf1", ovf1, 0);

        // Overflow: five kept samples into a 4-entry FIFO with no consumer
        do_reset();
        in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            din = 39'((k / 4 + 1) * 32768);
            @(negedge clk);
        end
        in_valid = 1'b0; din = '0;
        @(negedge clk);
        chk("ovf_level", fifo_level, 4);
        chk("ovf_set", ovf_sticky, 1);
        chk("ovf_head", dout, 1);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        chk("ovf_clr", ovf_sticky, 0);
        dout_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("ovf_valid", dout_valid, 1);
            chk("ovf_order", dout, i);
            @(negedge clk);
        end
        chk("ovf_drained", dout_valid, 0);
        chk("ovf_lvl0", fifo_level, 0);

        // Full FIFO with pop and write on the same edge
        do_reset();
        in_valid = 1'b1;
        for (int k = 0; k < 19; k++) begin
            din = 39'((k / 4 + 1) * 32768);
            dout_ready = (k == 18);
            if (k == 18) chk("fp_pre_level", fifo_level, 4);
            @(negedge clk);
        end
        in_valid = 1'b0; dout_ready = 1'b0;
        chk("fp_level", fifo_level, 4);
        chk("fp_ovf", ovf_sticky, 0);
        dout_ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            chk("fp_order", dout, i);
            @(negedge clk);
        end

        // Reset mid-operation with three buffered samples
        do_reset();
        in_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            din = 39'((k / 4 + 1) * 32768);
            @(negedge clk);
        end
        chk("mr_level3", fifo_level, 3);
        rst = 1'b1; din = 39'(7 * 32768);
        @(negedge clk);
        chk("mr_valid", dout_valid, 0);
        chk("mr_level", fifo_level, 0);
        rst = 1'b0; dout_ready = 1'b1; din = 39'(9 * 32768);
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            chk("mr_lat_valid", dout_valid, (k == 3) ? 1 : 0);
            if (k == 3) chk("mr_dout", dout, 9);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
